// File: rtl/fifo18k_ctrl_if.sv
// User-side port of the 1024 x 18 synchronous FIFO controller.
// The master issues write/read requests; the slave (the controller) returns data and status.
interface fifo18k_ctrl_if;
  logic        wr_en;
  logic [17:0] wr_data;
  logic        rd_en;
  logic [17:0] rd_data;
  logic        rd_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic        overflow;
  logic        underflow;
  logic [10:0] count;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           overflow, underflow, count
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           overflow, underflow, count
  );
endinterface

// File: rtl/fifo18k_ctrl.sv
// Synchronous 1024 x 18 FIFO controller driving one external 18Kb dual-port RAM
// (port A1 writes, port B1 reads with 1-cycle latency). All status flags are registered.
module fifo18k_ctrl #(
  parameter logic [10:0] ALMOST_FULL_THRESH  = 11'd1020,
  parameter logic [10:0] ALMOST_EMPTY_THRESH = 11'd4
) (
  input  logic           clk,
  input  logic           reset_n,
  fifo18k_ctrl_if.slave  bus,
  output logic           wen_a,
  output logic [1:0]     be_a,
  output logic [13:0]    addr_a,
  output logic [15:0]    wdata_a,
  output logic [1:0]     wparity_a,
  output logic           ren_b,
  output logic [13:0]    addr_b,
  input  logic [15:0]    rdata_b,
  input  logic [1:0]     rparity_b
);

  logic [10:0] wptr, rptr, wptr_nxt, rptr_nxt, count_nxt;
  logic [10:0] count_q;
  logic        full_q, empty_q, almost_full_q, almost_empty_q;
  logic        rd_valid_q, overflow_q, underflow_q;
  logic        wr_acc, rd_acc;

  // Accept decisions use only the registered flags, so a same-cycle read never
  // frees a full FIFO for writing and a same-cycle write never feeds an empty one.
  assign wr_acc = bus.wr_en && !full_q  && reset_n;
  assign rd_acc = bus.rd_en && !empty_q && reset_n;

  // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    wptr_nxt  = wptr + {10'd0, wr_acc};
    rptr_nxt  = rptr + {10'd0, rd_acc};
    count_nxt = wptr_nxt - rptr_nxt;
  end

  // The 10-bit RAM word index sits above four zero bits of the 14-bit port address.
  assign wen_a     = wr_acc;
  assign be_a      = wr_acc ? 2'b11 : 2'b00;
  assign addr_a    = {wptr[9:0], 4'b0000};
  assign wdata_a   = bus.wr_data[15:0];
  assign wparity_a = bus.wr_data[17:16];
  assign ren_b     = rd_acc;
  assign addr_b    = {rptr[9:0], 4'b0000};

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: only pointers and flags are reset; stored words stay in the RAM and are simply unreachable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr           <= '0;
      rptr           <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      rd_valid_q     <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wptr           <= wptr_nxt;
      rptr           <= rptr_nxt;
      count_q        <= count_nxt;
      full_q         <= (wptr_nxt[10] != rptr_nxt[10]) && (wptr_nxt[9:0] == rptr_nxt[9:0]);
      empty_q        <= (wptr_nxt == rptr_nxt);
      almost_full_q  <= (count_nxt >= ALMOST_FULL_THRESH);
      almost_empty_q <= (count_nxt <= ALMOST_EMPTY_THRESH);
      rd_valid_q     <= rd_acc;
      overflow_q     <= bus.wr_en && full_q;
      underflow_q    <= bus.rd_en && empty_q;
    end
  end

  assign bus.rd_data      = {rparity_b, rdata_b};
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
  assign bus.count        = count_q;

endmodule

// File: tb/tb_fifo18k_ctrl.sv
// Directed bench for fifo18k_ctrl with a behavioural 1024 x 18 RAM (1-cycle read latency).
module tb_fifo18k_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        wen_a, ren_b;
  logic [1:0]  be_a, wparity_a;
  logic [13:0] addr_a, addr_b;
  logic [15:0] wdata_a;
  logic [17:0] ram_q;
  logic [17:0] mem [1024];
  int          n_checks = 0;
  int          n_errors = 0;

  fifo18k_ctrl_if bus ();

  fifo18k_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .wen_a     (wen_a),
    .be_a      (be_a),
    .addr_a    (addr_a),
    .wdata_a   (wdata_a),
    .wparity_a (wparity_a),
    .ren_b     (ren_b),
    .addr_b    (addr_b),
    .rdata_b   (ram_q[15:0]),
    .rparity_b (ram_q[17:16])
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wen_a && be_a == 2'b11) mem[addr_a[13:4]] <= {wparity_a, wdata_a};
    if (ren_b) ram_q <= mem[addr_b[13:4]];
  end

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] pat(int i);
    logic [17:0] v;
    v = 18'(i * 131 + 7);
    return v;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_data = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.wr_data = 18'h3FFFF;
    tick();
    n_checks++; if (wen_a !== 1'b0) begin n_errors++; $display("FAIL reset_wen_a: got %b want 0", wen_a); end
    n_checks++; if (ren_b !== 1'b0) begin n_errors++; $display("FAIL reset_ren_b: got %b want 0", ren_b); end
    n_checks++; if (be_a !== 2'b00) begin n_errors++; $display("FAIL reset_be_a: got %b want 00", be_a); end
    n_checks++; if (bus.count !== 11'd0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_checks++; if (bus.empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    n_checks++; if (bus.almost_empty !== 1'b1) begin n_errors++; $display("FAIL reset_almost_empty: got %b want 1", bus.almost_empty); end
    n_checks++; if (bus.full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
    n_checks++; if (bus.almost_full !== 1'b0) begin n_errors++; $display("FAIL reset_almost_full: got %b want 0", bus.almost_full); end
    n_checks++; if (bus.rd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
    n_checks++; if ({bus.overflow, bus.underflow} !== 2'b00) begin n_errors++; $display("FAIL reset_err_pulses: got %b want 00", {bus.overflow, bus.underflow}); end
    n_checks++; if (addr_a !== 14'h0000 || addr_b !== 14'h0000) begin n_errors++; $display("FAIL reset_addr: got %h/%h want 0000/0000", addr_a, addr_b); end
    do_reset();
  endtask

  task automatic test_basic();
    logic [17:0] exp;
    for (int i = 0; i < 4; i++) begin
      exp = 18'h30001 + 18'(i);
      bus.wr_en = 1'b1;
      bus.wr_data = exp;
      #1;
      n_checks++; if (wen_a !== 1'b1 || be_a !== 2'b11) begin n_errors++; $display("FAIL basic_wen_be[%0d]: got %b/%b want 1/11", i, wen_a, be_a); end
      n_checks++; if (addr_a !== 14'(i * 16)) begin n_errors++; $display("FAIL basic_addr_a[%0d]: got %h want %h", i, addr_a, 14'(i * 16)); end
      n_checks++; if ({wparity_a, wdata_a} !== exp) begin n_errors++; $display("FAIL basic_wdata[%0d]: got %h want %h", i, {wparity_a, wdata_a}, exp); end
      tick();
      n_checks++; if (bus.count !== 11'(i + 1)) begin n_errors++; $display("FAIL basic_count_w[%0d]: got %0d want %0d", i, bus.count, i + 1); end
      n_checks++; if (bus.almost_empty !== 1'b1 || bus.empty !== 1'b0) begin n_errors++; $display("FAIL basic_flags_w[%0d]: got ae=%b e=%b want ae=1 e=0", i, bus.almost_empty, bus.empty); end
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = 18'h30001 + 18'(i);
      #1;
      n_checks++; if (ren_b !== 1'b1 || addr_b !== 14'(i * 16)) begin n_errors++; $display("FAIL basic_ren_addr_b[%0d]: got %b/%h want 1/%h", i, ren_b, addr_b, 14'(i * 16)); end
      tick();
      n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin n_errors++; $display("FAIL basic_rd_data[%0d]: got v=%b %h want v=1 %h", i, bus.rd_valid, bus.rd_data, exp); end
      n_checks++; if (bus.count !== 11'(3 - i) || bus.almost_empty !== 1'b1) begin n_errors++; $display("FAIL basic_count_r[%0d]: got %0d ae=%b want %0d ae=1", i, bus.count, bus.almost_empty, 3 - i); end
    end
    bus.rd_en = 1'b0;
    tick();
    n_checks++; if (bus.empty !== 1'b1 || bus.rd_valid !== 1'b0) begin n_errors++; $display("FAIL basic_end: got e=%b v=%b want e=1 v=0", bus.empty, bus.rd_valid); end
  endtask

  task automatic test_underflow();
    bus.rd_en = 1'b1;
    #1;
    n_checks++; if (ren_b !== 1'b0) begin n_errors++; $display("FAIL uf_ren_b: got %b want 0", ren_b); end
    tick();
    n_checks++; if (bus.underflow !== 1'b1) begin n_errors++; $display("FAIL uf_pulse: got %b want 1", bus.underflow); end
    n_checks++; if (bus.rd_valid !== 1'b0 || bus.count !== 11'd0) begin n_errors++; $display("FAIL uf_state: got v=%b c=%0d want v=0 c=0", bus.rd_valid, bus.count); end
    bus.rd_en = 1'b0;
    tick();
    n_checks++; if (bus.underflow !== 1'b0) begin n_errors++; $display("FAIL uf_pulse_end: got %b want 0", bus.underflow); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    bus.wr_en = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      bus.wr_data = pat(i);
      tick();
      if (i == 3) begin
        n_checks++; if (bus.almost_empty !== 1'b1) begin n_errors++; $display("FAIL ae_at_4: got %b want 1", bus.almost_empty); end
      end
      if (i == 4) begin
        n_checks++; if (bus.almost_empty !== 1'b0) begin n_errors++; $display("FAIL ae_at_5: got %b want 0", bus.almost_empty); end
      end
      if (i == 1018) begin
        n_checks++; if (bus.almost_full !== 1'b0) begin n_errors++; $display("FAIL af_at_1019: got %b want 0", bus.almost_full); end
      end
      if (i == 1019) begin
        n_checks++; if (bus.almost_full !== 1'b1) begin n_errors++; $display("FAIL af_at_1020: got %b want 1", bus.almost_full); end
      end
      if (i == 1022) begin
        n_checks++; if (bus.full !== 1'b0) begin n_errors++; $display("FAIL full_at_1023: got %b want 0", bus.full); end
      end
    end
    n_checks++; if (bus.full !== 1'b1 || bus.count !== 11'd1024) begin n_errors++; $display("FAIL full_1024: got f=%b c=%0d want f=1 c=1024", bus.full, bus.count); end
    bus.wr_data = 18'h3FFFF;
    #1;
    n_checks++; if (wen_a !== 1'b0 || be_a !== 2'b00) begin n_errors++; $display("FAIL ovf_wen_a: got %b/%b want 0/00", wen_a, be_a); end
    tick();
    n_checks++; if (bus.overflow !== 1'b1 || bus.count !== 11'd1024) begin n_errors++; $display("FAIL ovf_pulse: got o=%b c=%0d want o=1 c=1024", bus.overflow, bus.count); end
    // Write and read together while full: only the read is taken.
    bus.rd_en = 1'b1;
    #1;
    n_checks++; if (wen_a !== 1'b0 || ren_b !== 1'b1) begin n_errors++; $display("FAIL full_rw_accept: got w=%b r=%b want w=0 r=1", wen_a, ren_b); end
    tick();
    n_checks++; if (bus.overflow !== 1'b1 || bus.count !== 11'd1023) begin n_errors++; $display("FAIL full_rw_state: got o=%b c=%0d want o=1 c=1023", bus.overflow, bus.count); end
    n_checks++; if (bus.rd_data !== pat(0)) begin n_errors++; $display("FAIL full_rw_data: got %h want %h", bus.rd_data, pat(0)); end
    bus.wr_en = 1'b0;
    for (int k = 1; k < 1024; k++) begin
      tick();
      n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== pat(k)) begin n_errors++; $display("FAIL drain[%0d]: got v=%b %h want v=1 %h", k, bus.rd_valid, bus.rd_data, pat(k)); end
      if (k == 1) begin
        n_checks++; if (bus.overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_pulse_end: got %b want 0", bus.overflow); end
      end
    end
    bus.rd_en = 1'b0;
    tick();
    n_checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.count !== 11'd0) begin n_errors++; $display("FAIL wrap_empty: got e=%b f=%b c=%0d want e=1 f=0 c=0", bus.empty, bus.full, bus.count); end
    n_checks++; if (addr_b !== 14'h0000) begin n_errors++; $display("FAIL wrap_addr_b: got %h want 0000", addr_b); end
    bus.wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.wr_data = pat(2000 + i);
      #1;
      n_checks++; if (addr_a !== 14'(i * 16) || wen_a !== 1'b1) begin n_errors++; $display("FAIL wrap_addr_a[%0d]: got %h w=%b want %h w=1", i, addr_a, wen_a, 14'(i * 16)); end
      tick();
    end
    bus.wr_en = 1'b0;
    n_checks++; if (bus.count !== 11'd3 || bus.empty !== 1'b0) begin n_errors++; $display("FAIL wrap_count: got c=%0d e=%b want c=3 e=0", bus.count, bus.empty); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.wr_en = 1'b1;
    for (int i = 0; i < 512; i++) begin
      bus.wr_data = 18'h10000 + 18'(i);
      tick();
    end
    n_checks++; if (bus.count !== 11'd512) begin n_errors++; $display("FAIL b2b_fill: got %0d want 512", bus.count); end
    bus.rd_en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      bus.wr_data = 18'h10000 + 18'(512 + k);
      tick();
      n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 18'h10000 + 18'(k)) begin n_errors++; $display("FAIL b2b_data[%0d]: got v=%b %h want v=1 %h", k, bus.rd_valid, bus.rd_data, 18'h10000 + 18'(k)); end
      n_checks++; if (bus.count !== 11'd512) begin n_errors++; $display("FAIL b2b_count[%0d]: got %0d want 512", k, bus.count); end
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    tick();
    n_checks++; if (bus.count !== 11'd512 || bus.rd_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_end: got c=%0d v=%b want c=512 v=0", bus.count, bus.rd_valid); end
  endtask

  task automatic test_reset_mid();
    bus.wr_en = 1'b1;
    for (int j = 0; j < 188; j++) begin
      bus.wr_data = 18'h10000 + 18'(612 + j);
      tick();
    end
    n_checks++; if (bus.count !== 11'd700) begin n_errors++; $display("FAIL mid_count_700: got %0d want 700", bus.count); end
    bus.rd_en = 1'b1;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.count !== 11'd0 || bus.empty !== 1'b1 || bus.almost_empty !== 1'b1) begin n_errors++; $display("FAIL mid_rst_count: got c=%0d e=%b ae=%b want c=0 e=1 ae=1", bus.count, bus.empty, bus.almost_empty); end
    n_checks++; if (bus.full !== 1'b0 || bus.almost_full !== 1'b0 || bus.rd_valid !== 1'b0) begin n_errors++; $display("FAIL mid_rst_flags: got f=%b af=%b v=%b want 0/0/0", bus.full, bus.almost_full, bus.rd_valid); end
    n_checks++; if (wen_a !== 1'b0 || ren_b !== 1'b0 || addr_a !== 14'h0000 || addr_b !== 14'h0000) begin n_errors++; $display("FAIL mid_rst_ram: got w=%b r=%b %h/%h want 0/0 0000/0000", wen_a, ren_b, addr_a, addr_b); end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    bus.wr_en = 1'b1;
    bus.wr_data = 18'h2BEEF;
    #1;
    n_checks++; if (wen_a !== 1'b1 || addr_a !== 14'h0000) begin n_errors++; $display("FAIL mid_rt_write: got w=%b %h want w=1 0000", wen_a, addr_a); end
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 18'h2BEEF) begin n_errors++; $display("FAIL mid_rt_read: got v=%b %h want v=1 2beef", bus.rd_valid, bus.rd_data); end
    tick();
    n_checks++; if (bus.empty !== 1'b1 || bus.count !== 11'd0) begin n_errors++; $display("FAIL mid_rt_empty: got e=%b c=%0d want e=1 c=0", bus.empty, bus.count); end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_data = '0;
    #1;
    test_reset();
    test_basic();
    test_underflow();
    test_full_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/fifo18k_ctrl.md
FIFO18K_CTRL -- requirements
Module: fifo18k_ctrl

Interface
REQ-001 SHALL have parameter ALMOST_FULL_THRESH, default 11'd1020; ALMOST_FULL asserts when COUNT >= this value.
REQ-002 SHALL have parameter ALMOST_EMPTY_THRESH, default 11'd4; ALMOST_EMPTY asserts when COUNT <= this value.
REQ-003 CLK  input  1  single clock; all RAM-side port clocks (CLK_A1, CLK_B1) are tied to it externally.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 WR_EN  input  1  write request; WR_DATA  input  18  {parity[1:0], data[15:0]}.
REQ-006 RD_EN  input  1  read request; RD_DATA  output  18  read word; RD_VALID  output  1  RD_DATA qualifier.
REQ-007 FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY  output  1 each  status flags.
REQ-008 OVERFLOW, UNDERFLOW  output  1 each  one-cycle error pulses; COUNT  output  11  stored words, 0..1024.
REQ-009 RAM write side: WEN_A, BE_A[1:0], ADDR_A[13:0], WDATA_A[15:0], WPARITY_A[1:0]  outputs; these drive port A1 of one 18Kb dual-port RAM configured at 18-bit width.
REQ-010 RAM read side: REN_B, ADDR_B[13:0]  outputs; RDATA_B[15:0], RPARITY_B[1:0]  inputs; these connect to port B1 of the same RAM (18-bit width, 1-cycle read latency).

Function
REQ-011 Depth SHALL be 1024 words x 18 bits; write and read pointers SHALL be 11 bits (10-bit address plus wrap bit).
REQ-012 Write accepted iff WR_EN=1 and FULL=1'b0, with FULL sampled at the start of the cycle; a read in the same cycle does not make a full FIFO writable.
REQ-013 On an accepted write: WEN_A=1, BE_A=2'b11, ADDR_A={wptr[9:0],4'b0000}, WDATA_A=WR_DATA[15:0], WPARITY_A=WR_DATA[17:16] (combinational, same cycle); wptr increments at the clock edge.
REQ-014 Read accepted iff RD_EN=1 and EMPTY=1'b0, with EMPTY sampled at the start of the cycle; a write in the same cycle does not make an empty FIFO readable.
REQ-015 On an accepted read: REN_B=1, ADDR_B={rptr[9:0],4'b0000} (combinational); rptr increments at the edge.
REQ-016 RD_VALID SHALL be a registered copy of read-accept; RD_DATA={RPARITY_B,RDATA_B} passed through, valid only while RD_VALID=1; latency RD_EN->data = 1 cycle.
REQ-017 WEN_A/REN_B SHALL be 0 and BE_A=2'b00 when the corresponding request is not accepted; the address outputs still reflect the current pointer.
REQ-018 COUNT = wptr - rptr (mod 2048). It is +1 on a write only, -1 on a read only, and unchanged on a simultaneous accepted write and read.
REQ-019 FULL = (wptr[10]!=rptr[10]) && (wptr[9:0]==rptr[9:0]); EMPTY = (wptr==rptr); all flags SHALL be registered and update in the cycle after the pointer change.
REQ-020 OVERFLOW SHALL pulse for 1 cycle after a WR_EN while FULL; UNDERFLOW SHALL pulse for 1 cycle after an RD_EN while EMPTY. Rejected requests change no state.
REQ-021 Pointers SHALL wrap from 1023 to 0 with the wrap bit toggling; no address outside 0..1023 is ever issued.

Reset
REQ-022 RESET_N low SHALL asynchronously clear wptr, rptr, COUNT, RD_VALID, OVERFLOW, UNDERFLOW, FULL and ALMOST_FULL to 0.
REQ-023 RESET_N low SHALL force EMPTY=1 and ALMOST_EMPTY=1.
REQ-024 Combinational WEN_A/REN_B SHALL be forced to 0 while RESET_N=0.
REQ-025 Reset asserted mid-operation SHALL discard the stored contents logically; RAM contents are not cleared. Release is synchronous to the next CLK edge.

Verification
REQ-026 Reset, then write 0x3_0001..0x3_0004 and read 4 -> RD_DATA matches in order, each 1 cycle after RD_EN; EMPTY=1 at the end and ALMOST_EMPTY=1 throughout.
REQ-027 Write 1024 words -> FULL=1 and COUNT=1024 after the last edge; a 1025th WR_EN gives OVERFLOW=1 for 1 cycle, WEN_A=0, COUNT stays 1024.
REQ-028 RD_EN on an empty FIFO -> UNDERFLOW pulse, REN_B=0, RD_VALID=0, COUNT=0.
REQ-029 With COUNT=512, WR_EN and RD_EN high for 100 cycles -> COUNT stays 512 and the data order is preserved.
REQ-030 Fill 1024, drain 1024, then write 3 more -> ADDR_A sequence 0x0000,0x0010,0x0020 (wrap verified) and wrap bits are equal when EMPTY.
REQ-031 Assert RESET_N=0 mid-burst with COUNT=700 -> all outputs are at reset values within the same cycle (asynchronous); after release, a write/read round-trip works.
